pkt_slot_writer: RTL and testbench
==================================

Name: pkt_slot_writer

Overview:
- Sits directly downstream of the header-parser wrapper.
- Consumes the RX AXI-stream payload and the packet descriptor, writes each packet into a fixed-size slot of the packet buffer memory, and stamps the allocated slot index into the descriptor before forwarding it to the scheduler.
- Slots are returned via a free port once the scheduler/compute units finish with them.

Parameters:
DATA_WIDTH, 512, stream data width in bits
KEEP_WIDTH, 64, tkeep width (DATA_WIDTH/8)
DESC_WIDTH, 128, descriptor width (tied to `PANIC_DESC_WIDTH at instantiation)
SLOT_COUNT, 16, number of buffer slots (power of 2, ≥2)
SLOT_BEATS, 32, max beats per slot (power of 2)
SLOT_OF, 96, bit offset in descriptor where slot index is written
SLOT_W, $clog2(SLOT_COUNT), slot index width (derived)
BEAT_W, $clog2(SLOT_BEATS), beat offset width (derived)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
s_axis_tdata  in  DATA_WIDTH  payload beat
s_axis_tkeep  in  KEEP_WIDTH  byte enables
s_axis_tvalid  in  1  beat valid
s_axis_tready  out  1  beat accept
s_axis_tlast  in  1  last beat of packet
s_desc  in  DESC_WIDTH  descriptor from parser wrapper
s_desc_valid  in  1  descriptor valid
s_desc_ready  out  1  descriptor accept
m_desc  out  DESC_WIDTH  descriptor with slot index inserted
m_desc_valid  out  1  output descriptor valid
m_desc_ready  in  1  output descriptor accept
mem_wr_en  out  1  buffer write strobe
mem_wr_addr  out  SLOT_W+BEAT_W  {slot, beat offset}
mem_wr_data  out  DATA_WIDTH  write data
mem_wr_keep  out  KEEP_WIDTH  byte write enables
s_free_valid  in  1  slot release strobe (always accepted)
s_free_slot  in  SLOT_W  slot to release
free_count  out  SLOT_W+1  number of free slots
drop_count  out  32  packets dropped for overflow

Behaviour:
- Reset (async): state=IDLE, free map all ones, free_count=SLOT_COUNT, drop_count=0, desc register empty; all valid/enable outputs 0, data outputs 0.
- Allocation: lowest-index set bit of free map; clearing it on the accept of the packet's first beat.
- Descriptor register: 1 entry, independent of the data path. s_desc_ready = register empty. Descriptor may arrive before, during or after its packet's beats.
- States:
  - IDLE: s_axis_tready = (free_count≠0). First beat accepted → allocate slot, write offset 0. tlast → EMIT, else WRITE.
  - WRITE: s_axis_tready=1. Each accepted beat writes offset+1. tlast → EMIT. Accepting beat number SLOT_BEATS+1 (offset would wrap) → that beat not written, return slot to free map, → DROP (or DROP_DESC if that beat had tlast).
  - DROP: s_axis_tready=1, beats discarded; tlast → DROP_DESC.
  - DROP_DESC: s_axis_tready=0; when desc register full, discard it, drop_count+1 (saturating), → IDLE.
  - EMIT: s_axis_tready=0; m_desc_valid = desc register full. m_desc = stored desc with [SLOT_OF +: SLOT_W] replaced by slot. Hold stable until m_desc_ready. On handshake clear register → IDLE.
- Exactly SLOT_BEATS beats with tlast on the last fits, no drop.
- Memory write is registered: accepted beat appears on mem_wr_* the next cycle, mem_wr_en=1 for one cycle per written beat.
- Free port:
  - Sets the bit next cycle, free_count+1.
  - Free of an already-free slot: ignored, no count change.
  - Same-cycle free and allocate: both apply, free_count unchanged.
  - Same-cycle overflow release and external free of a different slot: both apply.
- free_count always equals popcount of free map.
- No combinational path from s_axis_tvalid to s_axis_tready.

Test Plan:
1. Single 1-beat packet (tlast=1, keep=all ones), desc=0 arrives same cycle → mem_wr_en one cycle later at addr 0; m_desc has slot field=0 after one IDLE→EMIT cycle; free_count 16→15.
2. 3-beat packet, desc arrives 5 cycles after tlast → writes to addrs 0,1,2; m_desc_valid asserted only after desc captured; s_axis_tready=0 while in EMIT.
3. SLOT_COUNT=2, send 3 packets, no frees → third packet stalls (tready=0). s_free_slot=0 pulse → third packet written to slot 0.
4. SLOT_BEATS=4, 6-beat packet → only 4 mem writes, no m_desc, drop_count=1, free_count back to SLOT_COUNT; next packet gets slot 0.
5. Free of slot 3 on the same cycle slot 4 is allocated → free_count unchanged. Double free of slot 3 → count unchanged.
6. m_desc_ready held low 10 cycles → m_desc stable; assert rst mid-WRITE → all outputs 0 immediately, free_count=SLOT_COUNT after release.

Source files
------------

// File: rtl/pkt_slot_writer_if.sv
// rtl/pkt_slot_writer_if.sv - stream, descriptor, buffer-write and free-port bundle for pkt_slot_writer
interface pkt_slot_writer_if #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int DESC_WIDTH = 128,
    parameter int SLOT_W     = 4,
    parameter int BEAT_W     = 5
);
    logic [DATA_WIDTH-1:0]      s_axis_tdata;
    logic [KEEP_WIDTH-1:0]      s_axis_tkeep;
    logic                       s_axis_tvalid;
    logic                       s_axis_tready;
    logic                       s_axis_tlast;

    logic [DESC_WIDTH-1:0]      s_desc;
    logic                       s_desc_valid;
    logic                       s_desc_ready;

    logic [DESC_WIDTH-1:0]      m_desc;
    logic                       m_desc_valid;
    logic                       m_desc_ready;

    logic                       mem_wr_en;
    logic [SLOT_W+BEAT_W-1:0]   mem_wr_addr;
    logic [DATA_WIDTH-1:0]      mem_wr_data;
    logic [KEEP_WIDTH-1:0]      mem_wr_keep;

    logic                       s_free_valid;
    logic [SLOT_W-1:0]          s_free_slot;

    // Environment side: drives payload, descriptors, frees; consumes outputs
    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        output s_desc, s_desc_valid,
        input  s_desc_ready,
        input  m_desc, m_desc_valid,
        output m_desc_ready,
        input  mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_keep,
        output s_free_valid, s_free_slot
    );

    // Writer side
    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        input  s_desc, s_desc_valid,
        output s_desc_ready,
        output m_desc, m_desc_valid,
        input  m_desc_ready,
        output mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_keep,
        input  s_free_valid, s_free_slot
    );
endinterface

// File: rtl/pkt_slot_writer.sv
// rtl/pkt_slot_writer.sv - writes packets into fixed buffer slots and stamps the slot into the descriptor
module pkt_slot_writer #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int DESC_WIDTH = 128,
    parameter int SLOT_COUNT = 16,
    parameter int SLOT_BEATS = 32,
    parameter int SLOT_OF    = 96,
    parameter int SLOT_W     = $clog2(SLOT_COUNT),
    parameter int BEAT_W     = $clog2(SLOT_BEATS)
) (
    input  logic             clk,
    input  logic             rst,
    pkt_slot_writer_if.slave bus,
    output logic [SLOT_W:0]  free_count,
    output logic [31:0]      drop_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_DROP,
        ST_DROP_DESC,
        ST_EMIT
    } state_t;

    state_t                 state, state_nxt;
    logic [SLOT_COUNT-1:0]  free_map, map_nxt;
    logic [SLOT_W:0]        count_nxt;
    logic [SLOT_W-1:0]      alloc_slot;
    logic [SLOT_W-1:0]      slot_q;
    // One bit wider than the beat offset so "slot already full" is its MSB
    logic [BEAT_W:0]        beat_cnt, cnt_nxt;

    logic [DESC_WIDTH-1:0]  desc_reg;
    logic                   desc_full;
    logic [DESC_WIDTH-1:0]  m_desc_c;

    logic                   tready;
    logic                   wr_now;
    logic [SLOT_W-1:0]      wr_slot;
    logic [BEAT_W-1:0]      wr_off;
    logic                   alloc;
    logic                   rel;
    logic                   desc_clr;
    logic                   drop_inc;
    logic                   m_valid;

    logic                   wr_en_q;
    logic [SLOT_W+BEAT_W-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0]  wr_data_q;
    logic [KEEP_WIDTH-1:0]  wr_keep_q;

    // Lowest-index free slot; only consumed in IDLE when free_count is nonzero
    always_comb begin
        alloc_slot = '0;
        for (int i = SLOT_COUNT - 1; i >= 0; i--) begin
            if (free_map[i]) begin
                alloc_slot = SLOT_W'(i);
            end
        end
    end

    // Next free map: external free and overflow release set bits, allocation clears
    always_comb begin
        map_nxt = free_map;
        if (bus.s_free_valid) begin
            map_nxt[bus.s_free_slot] = 1'b1;
        end
        if (rel) begin
            map_nxt[slot_q] = 1'b1;
        end
        if (alloc) begin
            map_nxt[alloc_slot] = 1'b0;
        end
        count_nxt = '0;
        for (int i = 0; i < SLOT_COUNT; i++) begin
            count_nxt = count_nxt + (SLOT_W+1)'(map_nxt[i]);
        end
    end

    // Next-state and per-cycle control; tready depends only on registered state
    always_comb begin
        state_nxt = state;
        tready    = 1'b0;
        wr_now    = 1'b0;
        wr_slot   = slot_q;
        wr_off    = beat_cnt[BEAT_W-1:0];
        alloc     = 1'b0;
        rel       = 1'b0;
        desc_clr  = 1'b0;
        drop_inc  = 1'b0;
        m_valid   = 1'b0;
        cnt_nxt   = beat_cnt;
        case (state)
            ST_IDLE: begin
                tready = (free_count != '0);
                if (bus.s_axis_tvalid && tready) begin
                    alloc     = 1'b1;
                    wr_now    = 1'b1;
                    wr_slot   = alloc_slot;
                    wr_off    = '0;
                    cnt_nxt   = (BEAT_W+1)'(1);
                    state_nxt = bus.s_axis_tlast ? ST_EMIT : ST_WRITE;
                end
            end
            ST_WRITE: begin
                tready = 1'b1;
                if (bus.s_axis_tvalid) begin
                    if (beat_cnt[BEAT_W]) begin
                        rel       = 1'b1;
                        state_nxt = bus.s_axis_tlast ? ST_DROP_DESC : ST_DROP;
                    end else begin
                        wr_now  = 1'b1;
                        cnt_nxt = beat_cnt + 1'b1;
                        if (bus.s_axis_tlast) begin
                            state_nxt = ST_EMIT;
                        end
                    end
                end
            end
            ST_DROP: begin
                tready = 1'b1;
                if (bus.s_axis_tvalid && bus.s_axis_tlast) begin
                    state_nxt = ST_DROP_DESC;
                end
            end
            ST_DROP_DESC: begin
                if (desc_full) begin
                    desc_clr  = 1'b1;
                    drop_inc  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_EMIT: begin
                m_valid = desc_full;
                if (desc_full && bus.m_desc_ready) begin
                    desc_clr  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stored descriptor with the slot index overlaid
    always_comb begin
        m_desc_c = desc_reg;
        m_desc_c[SLOT_OF +: SLOT_W] = slot_q;
    end

    // FSM state, current slot and beat counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            slot_q   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= cnt_nxt;
            if (alloc) begin
                slot_q <= alloc_slot;
            end
        end
    end

    // Free map, its popcount and the saturating drop counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_map   <= '1;
            free_count <= (SLOT_W+1)'(SLOT_COUNT);
            drop_count <= '0;
        end else begin
            free_map   <= map_nxt;
            free_count <= count_nxt;
            if (drop_inc && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

    // Single-entry descriptor holding register, filled independently of the payload
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            desc_full <= 1'b0;
            desc_reg  <= '0;
        end else if (desc_clr) begin
            desc_full <= 1'b0;
        end else if (bus.s_desc_valid && !desc_full) begin
            desc_full <= 1'b1;
            desc_reg  <= bus.s_desc;
        end
    end

    // Registered buffer write port, one strobe per written beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_keep_q <= '0;
        end else begin
            wr_en_q <= wr_now;
            if (wr_now) begin
                wr_addr_q <= {wr_slot, wr_off};
                wr_data_q <= bus.s_axis_tdata;
                wr_keep_q <= bus.s_axis_tkeep;
            end
        end
    end

    assign bus.s_axis_tready = tready;
    assign bus.s_desc_ready  = !desc_full;
    assign bus.m_desc_valid  = m_valid;
    assign bus.m_desc        = m_desc_c;
    assign bus.mem_wr_en     = wr_en_q;
    assign bus.mem_wr_addr   = wr_addr_q;
    assign bus.mem_wr_data   = wr_data_q;
    assign bus.mem_wr_keep   = wr_keep_q;

endmodule

// File: tb/tb_pkt_slot_writer.sv
// tb/tb_pkt_slot_writer.sv - scoreboard bench for pkt_slot_writer
module tb_pkt_slot_writer;

    localparam int DW    = 64;
    localparam int KW    = 8;
    localparam int DESCW = 128;
    localparam int SC    = 8;
    localparam int SB    = 4;
    localparam int SOF   = 96;
    localparam int SW    = 3;
    localparam int BW    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [SW:0]   free_count;
    logic [31:0]   drop_count;

    pkt_slot_writer_if #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DESC_WIDTH(DESCW), .SLOT_W(SW), .BEAT_W(BW)
    ) bus ();

    pkt_slot_writer #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DESC_WIDTH(DESCW),
        .SLOT_COUNT(SC), .SLOT_BEATS(SB), .SLOT_OF(SOF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .free_count (free_count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SW+BW-1:0] addr;
        logic [DW-1:0]    data;
        logic [KW-1:0]    keep;
    } wr_t;

    wr_t              exp_wr[$];
    logic [DESCW-1:0] exp_desc[$];
    logic [SC-1:0]    fm;
    int               exp_drop;
    int               checks   = 0;
    int               failures = 0;
    wr_t              mw;
    logic [DESCW-1:0] md;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int lowest_free();
        int r = -1;
        for (int i = SC - 1; i >= 0; i--) begin
            if (fm[i]) r = i;
        end
        return r;
    endfunction

    // Output monitor: pops the scoreboard on every write strobe and descriptor handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_wr_en) begin
                if (exp_wr.size() == 0) begin
                    check_val("wr_unexpected", 1, 0);
                end else begin
                    mw = exp_wr.pop_front();
                    check_val("wr_addr", bus.mem_wr_addr, mw.addr);
                    check_val("wr_data", bus.mem_wr_data, mw.data);
                    check_val("wr_keep", bus.mem_wr_keep, mw.keep);
                end
            end
            if (bus.m_desc_valid && bus.m_desc_ready) begin
                if (exp_desc.size() == 0) begin
                    check_val("desc_unexpected", 1, 0);
                end else begin
                    md = exp_desc.pop_front();
                    check_val("m_desc", bus.m_desc, md);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_desc(input logic [DESCW-1:0] d);
        bit acc = 0;
        int tmo = 0;
        bus.s_desc       = d;
        bus.s_desc_valid = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = bus.s_desc_ready;
            tmo++;
            @(posedge clk);
            #1;
            if (!acc && tmo > 300) begin
                check_val("desc_ready_timeout", 0, 1);
                acc = 1;
            end
        end
        bus.s_desc_valid = 1'b0;
    endtask

    // Drives n beats; tail=0 leaves the packet open (no tlast, no descriptor expected)
    task automatic send_pkt(input int n, input logic [DESCW-1:0] d, input bit tail);
        int slot = 0;
        int tmo;
        bit acc;
        logic [DESCW-1:0] dd;
        wr_t w;
        for (int i = 0; i < n; i++) begin
            bus.s_axis_tdata  = {$urandom, $urandom};
            bus.s_axis_tkeep  = (i == 0) ? {KW{1'b1}} : KW'($urandom_range(1, 255));
            bus.s_axis_tlast  = tail && (i == n - 1);
            bus.s_axis_tvalid = 1'b1;
            acc = 0;
            tmo = 0;
            while (!acc) begin
                @(negedge clk);
                if (bus.s_axis_tready) begin
                    acc = 1;
                    if (i == 0) begin
                        slot = lowest_free();
                        fm[slot] = 1'b0;
                    end
                    if (i < SB) begin
                        w.addr = {SW'(slot), BW'(i)};
                        w.data = bus.s_axis_tdata;
                        w.keep = bus.s_axis_tkeep;
                        exp_wr.push_back(w);
                    end else if (i == SB) begin
                        fm[slot] = 1'b1;
                    end
                end else begin
                    tmo++;
                end
                @(posedge clk);
                #1;
                if (!acc && tmo > 300) begin
                    check_val("tready_timeout", 0, 1);
                    bus.s_axis_tvalid = 1'b0;
                    bus.s_axis_tlast  = 1'b0;
                    return;
                end
            end
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        if (tail) begin
            if (n <= SB) begin
                dd = d;
                dd[SOF +: SW] = SW'(slot);
                exp_desc.push_back(dd);
            end else begin
                exp_drop++;
            end
        end
    endtask

    // Free pulse; the model sees the release at the clock edge, like the DUT
    task automatic free_slot(input int s);
        bus.s_free_valid = 1'b1;
        bus.s_free_slot  = SW'(s);
        @(posedge clk);
        fm[s] = 1'b1;
        #1;
        bus.s_free_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_wr.size() != 0 || exp_desc.size() != 0) && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_val("drain_wr", exp_wr.size(), 0);
        check_val("drain_desc", exp_desc.size(), 0);
    endtask

    task automatic pkt_with_desc(input int n);
        logic [DESCW-1:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        fork
            send_desc(d);
            send_pkt(n, d, 1);
        join
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DESCW-1:0] d;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tkeep  = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.s_desc        = '0;
        bus.s_desc_valid  = 1'b0;
        bus.m_desc_ready  = 1'b1;
        bus.s_free_valid  = 1'b0;
        bus.s_free_slot   = '0;
        fm       = '1;
        exp_drop = 0;

        // Reset state
        idle(2);
        check_val("rst_free_count", free_count, SC);
        check_val("rst_drop_count", drop_count, 0);
        check_val("rst_wr_en", bus.mem_wr_en, 0);
        check_val("rst_m_valid", bus.m_desc_valid, 0);
        check_val("rst_m_desc", bus.m_desc, 0);
        check_val("rst_desc_ready", bus.s_desc_ready, 1);
        rst = 1'b0;
        idle(1);

        // Single-beat packet with descriptor in the same cycle
        fork
            send_desc('0);
            send_pkt(1, '0, 1);
        join
        drain();
        check_val("t1_free_count", free_count, 7);

        // Three beats, descriptor five cycles after tlast
        d = 128'hdeadbeef_01234567_89abcdef_55aa33cc;
        send_pkt(3, d, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val("t2_tready_emit", bus.s_axis_tready, 0);
            check_val("t2_no_valid", bus.m_desc_valid, 0);
        end
        @(posedge clk);
        #1;
        idle(1);
        send_desc(d);
        drain();

        // Exhaust slots, then a stalled packet released by a free
        for (int k = 0; k < 6; k++) pkt_with_desc(1);
        drain();
        d = {$urandom, $urandom, $urandom, $urandom};
        fork
            send_desc(d);
            send_pkt(1, d, 1);
            begin
                repeat (4) @(negedge clk);
                check_val("t3_stall_tready", bus.s_axis_tready, 0);
                check_val("t3_free_zero", free_count, 0);
                @(posedge clk);
                #1;
                free_slot(2);
            end
        join
        drain();

        // Overflow drop and slot-length boundary
        for (int s = 0; s < SC; s++) free_slot(s);
        idle(1);
        check_val("t4_all_free", free_count, SC);
        pkt_with_desc(6);
        drain();
        idle(3);
        check_val("t4_drop_count", drop_count, exp_drop);
        check_val("t4_free_after_drop", free_count, $countones(fm));
        pkt_with_desc(1);
        pkt_with_desc(SB);
        pkt_with_desc(SB + 1);
        drain();
        idle(3);
        check_val("t4_drop_count2", drop_count, 2);
        check_val("t4_free_count2", free_count, $countones(fm));

        // Same-cycle free and allocate, then a double free
        pkt_with_desc(1);
        pkt_with_desc(1);
        drain();
        idle(2);
        d = {$urandom, $urandom, $urandom, $urandom};
        fork
            send_desc(d);
            send_pkt(1, d, 1);
            free_slot(3);
        join
        drain();
        idle(1);
        check_val("t5_same_cycle", free_count, 4);
        free_slot(3);
        idle(1);
        check_val("t5_double_free", free_count, 4);

        // Back-pressure on the output descriptor
        bus.m_desc_ready = 1'b0;
        pkt_with_desc(1);
        idle(2);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_val("t6_hold_valid", bus.m_desc_valid, 1);
            if (exp_desc.size() == 0) check_val("t6_hold_queue", 0, 1);
            else check_val("t6_hold_desc", bus.m_desc, exp_desc[0]);
        end
        @(posedge clk);
        #1;
        bus.m_desc_ready = 1'b1;
        drain();

        // Asynchronous reset in the middle of a packet
        send_pkt(2, '0, 0);
        rst = 1'b1;
        #1;
        check_val("t6_rst_wr_en", bus.mem_wr_en, 0);
        check_val("t6_rst_wr_addr", bus.mem_wr_addr, 0);
        check_val("t6_rst_wr_data", bus.mem_wr_data, 0);
        check_val("t6_rst_m_valid", bus.m_desc_valid, 0);
        check_val("t6_rst_drop", drop_count, 0);
        exp_wr.delete();
        exp_desc.delete();
        fm       = '1;
        exp_drop = 0;
        idle(2);
        rst = 1'b0;
        idle(1);
        check_val("t6_free_after_rst", free_count, SC);
        pkt_with_desc(1);
        drain();
        check_val("t6_final_free", free_count, SC - 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
